// File: rtl/nes_bus_pkg.sv
// Shared types and address map for the NES CPU-side bus controller.
// The region decoder lives here so the DMA engine and the top agree on one map.
package nes_bus_pkg;

   typedef enum logic [2:0] {IDLE, HALT, ALIGN, RD, WR} dma_state_e;

   typedef enum logic [2:0] {
      REG_RAM, REG_PPU, REG_APU, REG_DMA, REG_OPEN, REG_CART
   } bus_region_e;

   localparam logic [15:0] PPU_BASE  = 16'h2000;
   localparam logic [15:0] APU_BASE  = 16'h4000;
   localparam logic [15:0] APU_LAST  = 16'h4017;
   localparam logic [15:0] DMA_ADDR  = 16'h4014;
   localparam logic [15:0] CART_BASE = 16'h4020;

   function automatic bus_region_e decode_region(input logic [15:0] addr);
      bus_region_e r;
      if (addr < PPU_BASE) begin
         r = REG_RAM;
      end else if (addr < APU_BASE) begin
         r = REG_PPU;
      end else if (addr == DMA_ADDR) begin
         r = REG_DMA;
      end else if (addr <= APU_LAST) begin
         r = REG_APU;
      end else if (addr < CART_BASE) begin
         r = REG_OPEN;
      end else begin
         r = REG_CART;
      end
      return r;
   endfunction

endpackage

// File: rtl/nes_oam_dma.sv
// $4014 OAM DMA engine: halts the CPU, optionally aligns to the bus parity, then
// alternates a source read and a write to the PPU OAM data register per byte.
module nes_oam_dma
   import nes_bus_pkg::*;
#(
   parameter int unsigned DMA_LEN = 256,
   parameter int unsigned OAM_REG = 4
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   input  logic [7:0]  start_page,
   input  logic [7:0]  rd_data,
   output logic        active,
   output logic        rdy,
   output logic        bus_en,
   output logic [15:0] addr,
   output logic        rw_n,
   output logic [7:0]  wdata
);

   localparam logic [8:0]  LAST_IDX = 9'(DMA_LEN - 1);
   localparam logic [15:0] OAM_ADDR = PPU_BASE + 16'(OAM_REG);

   dma_state_e state;
   logic [7:0] page;
   logic [8:0] idx;
   logic [7:0] dma_buf;
   logic       parity;

   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= IDLE;
         page    <= 8'h00;
         idx     <= 9'd0;
         dma_buf <= 8'h00;
         parity  <= 1'b0;
         rdy     <= 1'b1;
         active  <= 1'b0;
      end else begin
         parity <= ~parity;
         case (state)
            IDLE: begin
               if (start) begin
                  state  <= HALT;
                  page   <= start_page;
                  idx    <= 9'd0;
                  rdy    <= 1'b0;
                  active <= 1'b1;
               end
            end
            // An odd halt cycle costs one extra idle cycle before the first read.
            HALT:  state <= parity ? ALIGN : RD;
            ALIGN: state <= RD;
            RD: begin
               dma_buf <= rd_data;
               state   <= WR;
            end
            WR: begin
               idx <= idx + 9'd1;
               if (idx == LAST_IDX) begin
                  state  <= IDLE;
                  rdy    <= 1'b1;
                  active <= 1'b0;
               end else begin
                  state <= RD;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   always_comb begin
      bus_en = (state == RD) || (state == WR);
      rw_n   = (state != WR);
      addr   = (state == WR) ? OAM_ADDR : {page, idx[7:0]};
      wdata  = dma_buf;
   end

endmodule

// File: rtl/nes_cpu_bus_ctrl.sv
// CPU-side NES bus controller: master mux between CPU and OAM DMA, address decode
// with RAM/PPU mirroring, read-data mux and the open-bus latch.
module nes_cpu_bus_ctrl
   import nes_bus_pkg::*;
#(
   parameter int unsigned RAM_AW     = 11,
   parameter int unsigned PPU_REG_AW = 3,
   parameter int unsigned DMA_LEN    = 256,
   parameter int unsigned OAM_REG    = 4
) (
   input  logic                  CPU_CLK,
   input  logic                  CPU_RESET,
   input  logic [15:0]           CPU_ADDR,
   input  logic [7:0]            CPU_DATA_OUT,
   input  logic                  CPU_RW_n,
   output logic [7:0]            CPU_DATA_IN,
   output logic                  CPU_RDY,
   output logic                  DMA_ACTIVE,
   output logic [RAM_AW-1:0]     SYSRAM_ADDR,
   output logic [7:0]            SYSRAM_WDATA,
   output logic                  SYSRAM_WREN,
   input  logic [7:0]            SYSRAM_RDATA,
   output logic                  PPU_CS,
   output logic [PPU_REG_AW-1:0] PPU_REG,
   output logic                  PPU_RW_n,
   output logic [7:0]            PPU_WDATA,
   input  logic [7:0]            PPU_RDATA,
   output logic                  APU_CS,
   output logic [4:0]            APU_ADDR,
   input  logic [7:0]            APU_RDATA,
   output logic                  CART_CS,
   output logic [15:0]           CART_ADDR,
   output logic                  CART_RW_n,
   output logic [7:0]            CART_WDATA,
   input  logic [7:0]            CART_RDATA
);

   logic [15:0] dma_addr;
   logic        dma_rw_n;
   logic [7:0]  dma_wdata;
   logic        dma_bus_en;
   logic        dma_start;

   logic [15:0] m_addr;
   logic        m_rw_n;
   logic [7:0]  m_wdata;
   logic        m_en;
   bus_region_e region;
   logic [7:0]  rd_data;
   logic [7:0]  open_bus;

   // Bus master: the DMA engine owns the bus whenever it is not idle.
   always_comb begin
      if (DMA_ACTIVE) begin
         m_addr  = dma_addr;
         m_rw_n  = dma_rw_n;
         m_wdata = dma_wdata;
         m_en    = dma_bus_en;
      end else begin
         m_addr  = CPU_ADDR;
         m_rw_n  = CPU_RW_n;
         m_wdata = CPU_DATA_OUT;
         m_en    = 1'b1;
      end
      if (CPU_RESET) begin
         m_en = 1'b0;
      end
   end

   assign region = decode_region(m_addr);

   always_comb begin
      case (region)
         REG_RAM:  rd_data = SYSRAM_RDATA;
         REG_PPU:  rd_data = PPU_RDATA;
         REG_APU:  rd_data = APU_RDATA;
         REG_CART: rd_data = CART_RDATA;
         default:  rd_data = open_bus;
      endcase
   end

   assign CPU_DATA_IN  = rd_data;

   assign SYSRAM_ADDR  = m_addr[RAM_AW-1:0];
   assign SYSRAM_WDATA = m_wdata;
   assign SYSRAM_WREN  = m_en && (region == REG_RAM) && !m_rw_n;

   assign PPU_CS       = m_en && (region == REG_PPU);
   assign PPU_REG      = m_addr[PPU_REG_AW-1:0];
   assign PPU_RW_n     = PPU_CS ? m_rw_n : 1'b1;
   assign PPU_WDATA    = m_wdata;

   assign APU_CS       = m_en && (region == REG_APU);
   assign APU_ADDR     = m_addr[4:0];

   assign CART_CS      = m_en && (region == REG_CART);
   assign CART_ADDR    = m_addr;
   assign CART_RW_n    = CART_CS ? m_rw_n : 1'b1;
   assign CART_WDATA   = m_wdata;

   assign dma_start    = !DMA_ACTIVE && !CPU_RESET && (region == REG_DMA) && !CPU_RW_n;

   // Whatever was last driven on the data bus lingers for unmapped reads.
   always_ff @(posedge CPU_CLK) begin
      if (CPU_RESET) begin
         open_bus <= 8'h00;
      end else if (m_en) begin
         open_bus <= m_rw_n ? rd_data : m_wdata;
      end
   end

   nes_oam_dma #(
      .DMA_LEN (DMA_LEN),
      .OAM_REG (OAM_REG)
   ) u_oam_dma (
      .clk        (CPU_CLK),
      .rst        (CPU_RESET),
      .start      (dma_start),
      .start_page (CPU_DATA_OUT),
      .rd_data    (rd_data),
      .active     (DMA_ACTIVE),
      .rdy        (CPU_RDY),
      .bus_en     (dma_bus_en),
      .addr       (dma_addr),
      .rw_n       (dma_rw_n),
      .wdata      (dma_wdata)
   );

   // The CPU is halted during DMA, so a $4014 write can only come from a broken master.
   dma_write_while_active: assert property (@(posedge CPU_CLK) disable iff (CPU_RESET)
      !(DMA_ACTIVE && (CPU_ADDR == DMA_ADDR) && !CPU_RW_n));

endmodule

// File: tb/tb_nes_cpu_bus_ctrl.sv
// Scoreboard bench: stimulus pushes one expected bus cycle per clock from a memory-map
// model; a negedge monitor pops and compares, and also measures every CPU_RDY stall.
module tb_nes_cpu_bus_ctrl;

   localparam int DMA_LEN = 256;

   logic        CPU_CLK = 1'b0;
   logic        CPU_RESET;
   logic [15:0] CPU_ADDR;
   logic [7:0]  CPU_DATA_OUT;
   logic        CPU_RW_n;
   logic [7:0]  CPU_DATA_IN;
   logic        CPU_RDY;
   logic        DMA_ACTIVE;
   logic [10:0] SYSRAM_ADDR;
   logic [7:0]  SYSRAM_WDATA;
   logic        SYSRAM_WREN;
   logic [7:0]  SYSRAM_RDATA;
   logic        PPU_CS;
   logic [2:0]  PPU_REG;
   logic        PPU_RW_n;
   logic [7:0]  PPU_WDATA;
   logic [7:0]  PPU_RDATA;
   logic        APU_CS;
   logic [4:0]  APU_ADDR;
   logic [7:0]  APU_RDATA;
   logic        CART_CS;
   logic [15:0] CART_ADDR;
   logic        CART_RW_n;
   logic [7:0]  CART_WDATA;
   logic [7:0]  CART_RDATA;

   always #5 CPU_CLK = ~CPU_CLK;

   nes_cpu_bus_ctrl dut (
      .CPU_CLK      (CPU_CLK),
      .CPU_RESET    (CPU_RESET),
      .CPU_ADDR     (CPU_ADDR),
      .CPU_DATA_OUT (CPU_DATA_OUT),
      .CPU_RW_n     (CPU_RW_n),
      .CPU_DATA_IN  (CPU_DATA_IN),
      .CPU_RDY      (CPU_RDY),
      .DMA_ACTIVE   (DMA_ACTIVE),
      .SYSRAM_ADDR  (SYSRAM_ADDR),
      .SYSRAM_WDATA (SYSRAM_WDATA),
      .SYSRAM_WREN  (SYSRAM_WREN),
      .SYSRAM_RDATA (SYSRAM_RDATA),
      .PPU_CS       (PPU_CS),
      .PPU_REG      (PPU_REG),
      .PPU_RW_n     (PPU_RW_n),
      .PPU_WDATA    (PPU_WDATA),
      .PPU_RDATA    (PPU_RDATA),
      .APU_CS       (APU_CS),
      .APU_ADDR     (APU_ADDR),
      .APU_RDATA    (APU_RDATA),
      .CART_CS      (CART_CS),
      .CART_ADDR    (CART_ADDR),
      .CART_RW_n    (CART_RW_n),
      .CART_WDATA   (CART_WDATA),
      .CART_RDATA   (CART_RDATA)
   );

   // Slave models driven only by DUT outputs.
   int unsigned ram_seed;
   logic        fill;
   logic [7:0]  bram [2048];

   function automatic logic [7:0] ram_init(input int i);
      return 8'((i * 37 + 11) ^ (i >> 3) ^ int'(ram_seed));
   endfunction

   always @(posedge CPU_CLK) begin
      if (CPU_RESET && fill) begin
         for (int i = 0; i < 2048; i++) bram[i] <= ram_init(i);
      end else if (SYSRAM_WREN) begin
         bram[SYSRAM_ADDR] <= SYSRAM_WDATA;
      end
   end

   assign SYSRAM_RDATA = bram[SYSRAM_ADDR];
   assign PPU_RDATA    = 8'h50 + {5'd0, PPU_REG};
   assign APU_RDATA    = 8'hA0 ^ {3'd0, APU_ADDR};
   assign CART_RDATA   = CART_ADDR[15:8] ^ CART_ADDR[7:0] ^ 8'h5A;

   typedef struct {
      logic        rdy, ram_chk, ram_we, ppu_cs, ppu_rw, apu_cs, cart_cs, cart_rw, dchk;
      logic [10:0] ram_addr;
      logic [2:0]  ppu_reg;
      logic [4:0]  apu_addr;
      logic [15:0] cart_addr;
      logic [7:0]  wdata, din;
      int          tag;
   } rec_t;

   rec_t sb[$];
   int   stall_q[$];
   int   checks = 0;
   int   errors = 0;
   logic mon_en = 1'b0;

   // Reference model state: what the NES memory map should hold.
   logic [7:0] ref_ram [2048];
   logic [7:0] ob;
   int         cyc;

   function automatic logic [7:0] model_read(input logic [15:0] a);
      if (a < 16'h2000)                        return ref_ram[a % 16'd2048];
      else if (a < 16'h4000)                   return 8'h50 + 8'(a % 16'd8);
      else if (a <= 16'h4017 && a != 16'h4014) return 8'hA0 ^ 8'(a % 16'd32);
      else if (a >= 16'h4020)                  return a[15:8] ^ a[7:0] ^ 8'h5A;
      else                                     return ob;
   endfunction

   task automatic chk(input string nm, input logic [15:0] got, input logic [15:0] want);
      checks++;
      if (got !== want) begin
         errors++;
         $display("FAIL %s got %0h want %0h", nm, got, want);
      end
   endtask

   task automatic push_idle();
      rec_t r;
      r = '{default: '0};
      r.tag = cyc;
      sb.push_back(r);
   endtask

   task automatic push_bus(input logic [15:0] a, input logic rw, input logic [7:0] wd,
                           input logic rdy, input logic cpu, output logic [7:0] v);
      rec_t r;
      r = '{default: '0};
      r.tag = cyc;
      r.rdy = rdy;
      v = rw ? model_read(a) : wd;
      if (a < 16'h2000) begin
         r.ram_chk  = 1'b1;
         r.ram_addr = 11'(a % 16'd2048);
         r.ram_we   = !rw;
      end else if (a < 16'h4000) begin
         r.ppu_cs  = 1'b1;
         r.ppu_reg = 3'(a % 16'd8);
         r.ppu_rw  = rw;
      end else if (a <= 16'h4017 && a != 16'h4014) begin
         r.apu_cs   = 1'b1;
         r.apu_addr = 5'(a % 16'd32);
      end else if (a >= 16'h4020) begin
         r.cart_cs   = 1'b1;
         r.cart_addr = a;
         r.cart_rw   = rw;
      end
      r.wdata = wd;
      r.dchk  = cpu && rw;
      r.din   = v;
      sb.push_back(r);
      ob = v;
      if (!rw && a < 16'h2000) ref_ram[a % 16'd2048] = wd;
   endtask

   task automatic step();
      cyc++;
      @(posedge CPU_CLK);
      #1;
   endtask

   task automatic cpu_cycle(input logic [15:0] a, input logic rw, input logic [7:0] wd);
      logic [7:0] v;
      CPU_ADDR     = a;
      CPU_RW_n     = rw;
      CPU_DATA_OUT = wd;
      push_bus(a, rw, wd, 1'b1, 1'b1, v);
      step();
   endtask

   task automatic rand_cycles(input int n);
      logic [15:0] a;
      logic        rw;
      for (int k = 0; k < n; k++) begin
         case ($urandom_range(0, 5))
            0:       a = 16'($urandom_range(16'h0000, 16'h1FFF));
            1:       a = 16'($urandom_range(16'h2000, 16'h3FFF));
            2:       a = 16'($urandom_range(16'h4000, 16'h4017));
            3:       a = 16'($urandom_range(16'h4018, 16'h401F));
            4:       a = 16'($urandom_range(16'h4020, 16'hFFFF));
            default: a = 16'h4014;
         endcase
         rw = 1'($urandom_range(0, 1));
         if (a == 16'h4014) rw = 1'b1;
         cpu_cycle(a, rw, 8'($urandom));
      end
   endtask

   // The engine aligns when its HALT cycle falls on odd parity; abort_wr >= 0
   // asserts reset in place of that OAM write.
   task automatic do_dma(input logic [7:0] page, input int align, input int abort_wr);
      logic [7:0]  v;
      logic [7:0]  dbuf;
      logic [15:0] a;
      if (((cyc + 1) % 2) != align) cpu_cycle(16'h0000, 1'b1, 8'h00);
      if (abort_wr < 0) stall_q.push_back(1 + align + 2 * DMA_LEN);
      else              stall_q.push_back(1 + align + 2 * abort_wr + 1);
      cpu_cycle(16'h4014, 1'b0, page);
      CPU_ADDR = 16'h0000;
      CPU_RW_n = 1'b1;
      push_idle();
      step();
      if (align == 1) begin
         push_idle();
         step();
      end
      for (int i = 0; i < DMA_LEN; i++) begin
         a = {page, 8'(i)};
         push_bus(a, 1'b1, 8'h00, 1'b0, 1'b0, v);
         dbuf = v;
         step();
         if (i == abort_wr) begin
            CPU_RESET = 1'b1;
            @(negedge CPU_CLK);
            chk("rst_held_ppu_cs", 16'(PPU_CS), 16'd0);
            @(posedge CPU_CLK);
            #1;
            @(negedge CPU_CLK);
            chk("rst_next_rdy", 16'(CPU_RDY), 16'd1);
            chk("rst_next_active", 16'(DMA_ACTIVE), 16'd0);
            chk("rst_next_ppu_cs", 16'(PPU_CS), 16'd0);
            @(posedge CPU_CLK);
            #1;
            CPU_RESET = 1'b0;
            cyc = 0;
            ob  = 8'h00;
            return;
         end
         push_bus(16'h2004, 1'b0, dbuf, 1'b0, 1'b0, v);
         step();
      end
   endtask

   // Monitor
   rec_t mr;
   logic mbad;
   int   stall = 0;

   task automatic mfail(input string nm, input int got, input int want);
      $display("FAIL %s cyc=%0d got %0h want %0h", nm, mr.tag, got, want);
      mbad = 1'b1;
   endtask

   always @(negedge CPU_CLK) begin
      if (mon_en && !CPU_RESET) begin
         if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_cycle got %0h want none", CPU_ADDR);
         end else begin
            mr   = sb.pop_front();
            mbad = 1'b0;
            checks++;
            if (CPU_RDY !== mr.rdy)       mfail("cpu_rdy", int'(CPU_RDY), int'(mr.rdy));
            if (DMA_ACTIVE !== !mr.rdy)   mfail("dma_active", int'(DMA_ACTIVE), int'(!mr.rdy));
            if (SYSRAM_WREN !== mr.ram_we) mfail("sysram_wren", int'(SYSRAM_WREN), int'(mr.ram_we));
            if (PPU_CS !== mr.ppu_cs)     mfail("ppu_cs", int'(PPU_CS), int'(mr.ppu_cs));
            if (APU_CS !== mr.apu_cs)     mfail("apu_cs", int'(APU_CS), int'(mr.apu_cs));
            if (CART_CS !== mr.cart_cs)   mfail("cart_cs", int'(CART_CS), int'(mr.cart_cs));
            if (mr.ram_chk && SYSRAM_ADDR !== mr.ram_addr)
               mfail("sysram_addr", int'(SYSRAM_ADDR), int'(mr.ram_addr));
            if (mr.ram_we && SYSRAM_WDATA !== mr.wdata)
               mfail("sysram_wdata", int'(SYSRAM_WDATA), int'(mr.wdata));
            if (mr.ppu_cs && (PPU_REG !== mr.ppu_reg || PPU_RW_n !== mr.ppu_rw))
               mfail("ppu_reg_rw", int'({PPU_REG, PPU_RW_n}), int'({mr.ppu_reg, mr.ppu_rw}));
            if (mr.ppu_cs && !mr.ppu_rw && PPU_WDATA !== mr.wdata)
               mfail("ppu_wdata", int'(PPU_WDATA), int'(mr.wdata));
            if (mr.apu_cs && APU_ADDR !== mr.apu_addr)
               mfail("apu_addr", int'(APU_ADDR), int'(mr.apu_addr));
            if (mr.cart_cs && (CART_ADDR !== mr.cart_addr || CART_RW_n !== mr.cart_rw))
               mfail("cart_addr_rw", int'({CART_ADDR, CART_RW_n}), int'({mr.cart_addr, mr.cart_rw}));
            if (mr.cart_cs && !mr.cart_rw && CART_WDATA !== mr.wdata)
               mfail("cart_wdata", int'(CART_WDATA), int'(mr.wdata));
            if (mr.dchk && CPU_DATA_IN !== mr.din)
               mfail("cpu_data_in", int'(CPU_DATA_IN), int'(mr.din));
            if (mbad) errors++;
         end
         if (CPU_RDY !== 1'b1) begin
            stall++;
         end else if (stall != 0) begin
            checks++;
            if (stall_q.size() == 0) begin
               errors++;
               $display("FAIL stall_len got %0d want none", stall);
            end else begin
               int want;
               want = stall_q.pop_front();
               if (stall != want) begin
                  errors++;
                  $display("FAIL stall_len got %0d want %0d", stall, want);
               end
            end
            stall = 0;
         end
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog got timeout want finish");
      $fatal(1, "watchdog");
   end

   initial begin
      ram_seed     = $urandom;
      fill         = 1'b1;
      CPU_RESET    = 1'b1;
      CPU_ADDR     = 16'h2000;
      CPU_RW_n     = 1'b0;
      CPU_DATA_OUT = 8'hFF;
      for (int i = 0; i < 2048; i++) ref_ram[i] = ram_init(i);
      repeat (3) @(posedge CPU_CLK);
      @(negedge CPU_CLK);
      chk("reset_rdy", 16'(CPU_RDY), 16'd1);
      chk("reset_active", 16'(DMA_ACTIVE), 16'd0);
      chk("reset_cs", 16'({PPU_CS, APU_CS, CART_CS, SYSRAM_WREN}), 16'd0);
      chk("reset_rw_n", 16'({PPU_RW_n, CART_RW_n}), 16'd3);
      @(posedge CPU_CLK);
      #1;
      CPU_RESET = 1'b0;
      fill      = 1'b0;
      cyc       = 0;
      ob        = 8'h00;
      mon_en    = 1'b1;

      cpu_cycle(16'h4018, 1'b1, 8'h00);
      cpu_cycle(16'h0005, 1'b0, 8'hA5);
      cpu_cycle(16'h0805, 1'b1, 8'h00);
      cpu_cycle(16'h1805, 1'b1, 8'h00);
      cpu_cycle(16'h3456, 1'b0, 8'h80);
      cpu_cycle(16'h80E6, 1'b1, 8'h00);
      cpu_cycle(16'h4018, 1'b1, 8'h00);

      rand_cycles(400);
      do_dma(8'h02, 0, -1);
      rand_cycles(20);
      do_dma(8'h02, 1, -1);
      rand_cycles(20);
      do_dma(8'h21, int'($urandom_range(0, 1)), -1);
      rand_cycles(20);
      do_dma(8'($urandom_range(0, 255)), int'($urandom_range(0, 1)), -1);
      rand_cycles(20);
      do_dma(8'h03, int'($urandom_range(0, 1)), 99);
      cpu_cycle(16'h401C, 1'b1, 8'h00);
      rand_cycles(60);

      @(negedge CPU_CLK);
      mon_en = 1'b0;
      chk("scoreboard_drained", 16'(sb.size()), 16'd0);
      chk("stalls_drained", 16'(stall_q.size()), 16'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
